// File: rtl/seg7_reader.sv
// Seven-segment scan-bus reader: decodes a multiplexed active-low segment bus
// back into hex nibbles and publishes one packed frame per complete digit set.
module seg7_reader #(
   parameter int unsigned NUM_DIGITS     = 6,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    scan_valid,
   input  logic [2:0]              scan_digit,
   input  logic [6:0]              scan_seg,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   blank_mask,
   output logic                    frame_valid,
   output logic                    frame_error,
   output logic                    timeout
);

   localparam int unsigned ND = NUM_DIGITS;
   localparam int unsigned VW = 4 * NUM_DIGITS;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [0:0] {
      S_IDLE,
      S_COLLECT
   } state_t;

   state_t        state;
   logic [ND-1:0] seen;
   logic [ND-1:0] cap_blank;
   logic [ND-1:0] cap_err;
   logic [VW-1:0] cap_val;
   logic [TW-1:0] timer;
   logic          publish;

   logic [3:0]    dec_nib_c;
   logic          dec_blank_c;
   logic          dec_err_c;
   logic          accept_c;
   logic [ND-1:0] digit_hot_c;
   logic [ND-1:0] seen_next_c;
   logic          frame_done_c;

   // Segment pattern to nibble; blank and unknown patterns both decode to 0
   always_comb begin
      dec_nib_c   = 4'h0;
      dec_blank_c = 1'b0;
      dec_err_c   = 1'b0;
      case (scan_seg)
         7'h40:   dec_nib_c = 4'h0;
         7'h79:   dec_nib_c = 4'h1;
         7'h24:   dec_nib_c = 4'h2;
         7'h30:   dec_nib_c = 4'h3;
         7'h19:   dec_nib_c = 4'h4;
         7'h12:   dec_nib_c = 4'h5;
         7'h02:   dec_nib_c = 4'h6;
         7'h78:   dec_nib_c = 4'h7;
         7'h00:   dec_nib_c = 4'h8;
         7'h18:   dec_nib_c = 4'h9;
         7'h08:   dec_nib_c = 4'hA;
         7'h03:   dec_nib_c = 4'hB;
         7'h46:   dec_nib_c = 4'hC;
         7'h21:   dec_nib_c = 4'hD;
         7'h06:   dec_nib_c = 4'hE;
         7'h0E:   dec_nib_c = 4'hF;
         7'h7F:   dec_blank_c = 1'b1;
         default: dec_err_c = 1'b1;
      endcase
   end

   // Out-of-range digit indices are invisible to the rest of the logic
   always_comb begin
      accept_c     = scan_valid && (4'(scan_digit) < 4'(NUM_DIGITS));
      digit_hot_c  = accept_c ? (ND'(1) << scan_digit) : '0;
      seen_next_c  = seen | digit_hot_c;
      frame_done_c = accept_c && (&seen_next_c);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         seen        <= '0;
         cap_val     <= '0;
         cap_blank   <= '0;
         cap_err     <= '0;
         timer       <= '0;
         publish     <= 1'b0;
         value       <= '0;
         blank_mask  <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         frame_valid <= publish;
         timeout     <= 1'b0;
         publish     <= 1'b0;

         // Publish reads the capture regs before any same-edge overwrite
         if (publish) begin
            value       <= cap_val;
            blank_mask  <= cap_blank;
            frame_error <= |cap_err;
         end

         for (int i = 0; i < int'(ND); i++) begin
            if (digit_hot_c[i]) begin
               cap_val[4*i +: 4] <= dec_nib_c;
               cap_blank[i]      <= dec_blank_c;
               cap_err[i]        <= dec_err_c;
            end
         end

         case (state)
            S_IDLE: begin
               timer <= '0;
               if (accept_c) begin
                  if (frame_done_c) begin
                     seen    <= '0;
                     publish <= 1'b1;
                  end else begin
                     seen  <= seen_next_c;
                     state <= S_COLLECT;
                  end
               end
            end
            S_COLLECT: begin
               if (accept_c) begin
                  timer <= '0;
                  if (frame_done_c) begin
                     seen    <= '0;
                     publish <= 1'b1;
                     state   <= S_IDLE;
                  end else begin
                     seen <= seen_next_c;
                  end
               end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  timeout <= 1'b1;
                  seen    <= '0;
                  timer   <= '0;
                  state   <= S_IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
         endcase
      end
   end

endmodule
